// File: rtl/seq_stream_gen.sv
// Serial pattern transmitter: loads a parallel word and a bit count, then shifts
// the pattern out MSB-first with a valid qualifier, optionally looping it forever.
module seq_stream_gen #(
  parameter int WIDTH = 16,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  input  logic             loop_en,
  input  logic             stop,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_save;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_cnt;

  logic [LW-1:0]    w_lenClamp;
  logic [LW-1:0]    w_shiftAmt;
  logic [WIDTH-1:0] w_aligned;
  logic             w_accept;
  logic             w_lastBit;

  // Left-align the requested bits so the first bit to send always sits in the MSB.
  assign w_lenClamp = (load_len > WIDTH_L) ? WIDTH_L : load_len;
  assign w_shiftAmt = WIDTH_L - w_lenClamp;
  assign w_aligned  = load_data << w_shiftAmt;
  assign w_accept   = (r_state == IDLE) && start && (load_len != '0);
  assign w_lastBit  = (r_cnt == ONE_L);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Stop wins over both the loop reload and the move to DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = SEND;
        end
      end
      SEND: begin
        if (stop) begin
          w_nextState = IDLE;
        end else if (w_lastBit && !loop_en) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_save  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= w_aligned;
            r_save  <= w_aligned;
            r_len   <= w_lenClamp;
            r_cnt   <= w_lenClamp;
          end
        end
        SEND: begin
          if (stop) begin
            r_shreg <= '0;
            r_cnt   <= '0;
          end else if (w_lastBit && loop_en) begin
            r_shreg <= r_save;
            r_cnt   <= r_len;
          end else begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - ONE_L;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dout       = (r_state == SEND) & r_shreg[WIDTH-1];
  assign dout_valid = (r_state == SEND);
  assign busy       = (r_state == SEND) || (r_state == DONE);
  assign done       = (r_state == DONE);

endmodule
